// File: rtl/frame_minmax.sv
// frame_minmax: streaming signed min/max reduction over valid/ready frames.
// Each frame reports min, max, first-occurrence index of each, a
// saturating beat count and an overflow flag. The comparator_lt and
// comparator_eq helpers below do all sample comparisons.

// Signed strict less-than: lt = (a < b) in two's complement.
module comparator_lt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    assign lt = ($signed(a) < $signed(b));

endmodule

// Bitwise equality: eq = (a == b).
module comparator_eq #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq
);

    assign eq = (a == b);

endmodule

module frame_minmax #(
    parameter int N       = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_min,
    output logic [N-1:0]       out_max,
    output logic [COUNT_W-1:0] out_min_idx,
    output logic [COUNT_W-1:0] out_max_idx,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // The count saturates here; an index taken while saturated also reads
    // this value because the beat index is simply the current count.
    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]       DATA_ZERO = {N{1'b0}};

    state_t              state_q, state_d;
    logic [N-1:0]        min_q, min_d;
    logic [N-1:0]        max_q, max_d;
    logic [COUNT_W-1:0]  min_idx_q, min_idx_d;
    logic [COUNT_W-1:0]  max_idx_q, max_idx_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                overflow_q, overflow_d;
    // Debug-only: every sample of the current frame equals the first one.
    logic                all_equal_q, all_equal_d;

    logic                accept_s;
    logic                deliver_s;
    logic                new_min_s;
    logic                new_max_s;
    logic                same_s;
    logic                cnt_sat_s;

    // New sample is strictly below the running minimum.
    comparator_lt #(.N(N)) u_lt_min (
        .a  (in_data),
        .b  (min_q),
        .lt (new_min_s)
    );

    // Running maximum is strictly below the new sample.
    comparator_lt #(.N(N)) u_lt_max (
        .a  (max_q),
        .b  (in_data),
        .lt (new_max_s)
    );

    // While all samples are equal the minimum still holds the first sample,
    // so comparing against it tracks the all-equal condition.
    comparator_eq #(.N(N)) u_eq (
        .a  (in_data),
        .b  (min_q),
        .eq (same_s)
    );

    // Handshakes decode straight from state so out_ready never reaches in_ready.
    assign in_ready  = (state_q != S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign accept_s  = in_valid & in_ready;
    assign deliver_s = out_valid & out_ready;
    assign cnt_sat_s = (count_q == CNT_MAX);

    // Results are presented directly from the accumulation registers.
    assign out_min      = min_q;
    assign out_max      = max_q;
    assign out_min_idx  = min_idx_q;
    assign out_max_idx  = max_idx_q;
    assign out_count    = count_q;
    assign out_overflow = overflow_q;

    // Next-state and accumulator update logic for the frame FSM.
    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        max_d       = max_q;
        min_idx_d   = min_idx_q;
        max_idx_d   = max_idx_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        all_equal_d = all_equal_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    // First beat seeds both extremes at index 0.
                    min_d       = in_data;
                    max_d       = in_data;
                    min_idx_d   = CNT_ZERO;
                    max_idx_d   = CNT_ZERO;
                    count_d     = CNT_ONE;
                    overflow_d  = 1'b0;
                    all_equal_d = 1'b1;
                    if (in_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ACCUM: begin
                if (accept_s) begin
                    // Strict compares: ties keep the earlier index.
                    if (new_min_s) begin
                        min_d     = in_data;
                        min_idx_d = count_q;
                    end else begin
                        min_d     = min_q;
                        min_idx_d = min_idx_q;
                    end

                    if (new_max_s) begin
                        max_d     = in_data;
                        max_idx_d = count_q;
                    end else begin
                        max_d     = max_q;
                        max_idx_d = max_idx_q;
                    end

                    if (cnt_sat_s) begin
                        count_d    = count_q;
                        overflow_d = 1'b1;
                    end else begin
                        count_d    = count_q + CNT_ONE;
                        overflow_d = overflow_q;
                    end

                    all_equal_d = all_equal_q & same_s;

                    if (in_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end

            S_DONE: begin
                // Hold results until the consumer takes them.
                if (deliver_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and accumulator registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            min_q       <= DATA_ZERO;
            max_q       <= DATA_ZERO;
            min_idx_q   <= CNT_ZERO;
            max_idx_q   <= CNT_ZERO;
            count_q     <= CNT_ZERO;
            overflow_q  <= 1'b0;
            all_equal_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            max_q       <= max_d;
            min_idx_q   <= min_idx_d;
            max_idx_q   <= max_idx_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            all_equal_q <= all_equal_d;
        end
    end

endmodule

// File: tb/tb_frame_minmax.sv
// Scoreboard bench for frame_minmax: two instances (COUNT_W=8 and 3) share
// the same input stream; expected frame results are queued at stimulus time
// and popped by per-instance monitors whenever a result is delivered.
module tb_frame_minmax;

    typedef struct packed {
        logic [31:0] mn;
        logic [31:0] mx;
        logic [7:0]  mn_i;
        logic [7:0]  mx_i;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        o8_in_ready, o8_valid, o8_ovf;
    logic [31:0] o8_min, o8_max;
    logic [7:0]  o8_min_idx, o8_max_idx, o8_count;

    logic        o3_in_ready, o3_valid, o3_ovf;
    logic [31:0] o3_min, o3_max;
    logic [2:0]  o3_min_idx, o3_max_idx, o3_count;

    exp_t q8[$];
    exp_t q3[$];
    exp_t e8;
    exp_t e3;
    logic [31:0] vq[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_minmax #(.N(32), .COUNT_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(o8_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(o8_valid), .out_ready(out_ready),
        .out_min(o8_min), .out_max(o8_max),
        .out_min_idx(o8_min_idx), .out_max_idx(o8_max_idx),
        .out_count(o8_count), .out_overflow(o8_ovf)
    );

    frame_minmax #(.N(32), .COUNT_W(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(o3_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(o3_valid), .out_ready(out_ready),
        .out_min(o3_min), .out_max(o3_max),
        .out_min_idx(o3_min_idx), .out_max_idx(o3_max_idx),
        .out_count(o3_count), .out_overflow(o3_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] mn, input logic [31:0] mx,
                                input logic [7:0] mi, input logic [7:0] xi,
                                input logic [7:0] c, input logic o);
        exp_t r;
        r.mn = mn; r.mx = mx; r.mn_i = mi; r.mx_i = xi; r.cnt = c; r.ovf = o;
        return r;
    endfunction

    // Monitor for the COUNT_W=8 instance.
    always @(negedge clk) begin
        if (!rst && o8_valid && out_ready) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut8 unexpected result: min %h max %h", o8_min, o8_max);
            end else begin
                e8 = q8.pop_front();
                chk("dut8 min",      o8_min,                 e8.mn);
                chk("dut8 max",      o8_max,                 e8.mx);
                chk("dut8 min_idx",  {24'd0, o8_min_idx},    {24'd0, e8.mn_i});
                chk("dut8 max_idx",  {24'd0, o8_max_idx},    {24'd0, e8.mx_i});
                chk("dut8 count",    {24'd0, o8_count},      {24'd0, e8.cnt});
                chk("dut8 overflow", {31'd0, o8_ovf},        {31'd0, e8.ovf});
            end
        end
    end

    // Monitor for the COUNT_W=3 instance.
    always @(negedge clk) begin
        if (!rst && o3_valid && out_ready) begin
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut3 unexpected result: min %h max %h", o3_min, o3_max);
            end else begin
                e3 = q3.pop_front();
                chk("dut3 min",      o3_min,                 e3.mn);
                chk("dut3 max",      o3_max,                 e3.mx);
                chk("dut3 min_idx",  {29'd0, o3_min_idx},    {24'd0, e3.mn_i});
                chk("dut3 max_idx",  {29'd0, o3_max_idx},    {24'd0, e3.mx_i});
                chk("dut3 count",    {29'd0, o3_count},      {24'd0, e3.cnt});
                chk("dut3 overflow", {31'd0, o3_ovf},        {31'd0, e3.ovf});
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic last);
        int n = 0;
        while (!o8_in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o8_in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready timeout: got 0 expected 1");
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends vq as one frame; expectations are queued before the last beat.
    task automatic run_frame(input exp_t x8, input exp_t x3);
        q8.push_back(x8);
        q3.push_back(x3);
        for (int i = 0; i < vq.size(); i++) begin
            send_beat(vq[i], (i == vq.size() - 1));
        end
        chk("out_valid on last edge", {31'd0, o8_valid},    32'd1);
        chk("in_ready low in done",   {31'd0, o8_in_ready}, 32'd0);
        chk("dut3 out_valid on last", {31'd0, o3_valid},    32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q3.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (q8.size() != 0 || q3.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain timeout: pending %0d expected 0", q8.size() + q3.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " out_valid"}, {31'd0, o8_valid},    32'd0);
        chk({tag, " in_ready"},  {31'd0, o8_in_ready}, 32'd1);
        chk({tag, " min"},       o8_min,               32'd0);
        chk({tag, " max"},       o8_max,               32'd0);
        chk({tag, " min_idx"},   {24'd0, o8_min_idx},  32'd0);
        chk({tag, " max_idx"},   {24'd0, o8_max_idx},  32'd0);
        chk({tag, " count"},     {24'd0, o8_count},    32'd0);
        chk({tag, " overflow"},  {31'd0, o8_ovf},      32'd0);
        chk({tag, " dut3 count"},{29'd0, o3_count},    32'd0);
        chk({tag, " dut3 min"},  o3_min,               32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Mixed frame: min -1 at 1, max 38273 at 3.
        vq = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'd38273};
        run_frame(mk(32'hFFFF_FFFF, 32'd38273, 8'd1, 8'd3, 8'd4, 1'b0),
                  mk(32'hFFFF_FFFF, 32'd38273, 8'd1, 8'd3, 8'd4, 1'b0));
        drain();

        // Signed extremes.
        vq = '{32'h7FFF_FFFF, 32'h8000_0000};
        run_frame(mk(32'h8000_0000, 32'h7FFF_FFFF, 8'd1, 8'd0, 8'd2, 1'b0),
                  mk(32'h8000_0000, 32'h7FFF_FFFF, 8'd1, 8'd0, 8'd2, 1'b0));
        drain();

        // Ties keep the first occurrence.
        vq = '{32'd7, 32'd7, 32'd3, 32'd3, 32'd9, 32'd9};
        run_frame(mk(32'd3, 32'd9, 8'd2, 8'd4, 8'd6, 1'b0),
                  mk(32'd3, 32'd9, 8'd2, 8'd4, 8'd6, 1'b0));
        drain();

        // Single beat under backpressure.
        out_ready = 1'b0;
        vq = '{32'd1000};
        run_frame(mk(32'd1000, 32'd1000, 8'd0, 8'd0, 8'd1, 1'b0),
                  mk(32'd1000, 32'd1000, 8'd0, 8'd0, 8'd1, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp out_valid held", {31'd0, o8_valid},    32'd1);
            chk("bp in_ready low",   {31'd0, o8_in_ready}, 32'd0);
            chk("bp min stable",     o8_min,               32'd1000);
            chk("bp max stable",     o8_max,               32'd1000);
            chk("bp count stable",   {24'd0, o8_count},    32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("after deliver out_valid", {31'd0, o8_valid},    32'd0);
        chk("after deliver in_ready",  {31'd0, o8_in_ready}, 32'd1);
        chk("after deliver queue",     q8.size(),            32'd0);

        // Nine beats: saturates the 3-bit instance, minimum on beat 8.
        vq = '{32'd50, 32'd40, 32'd45, 32'd30, 32'd35, 32'd20, 32'd25, 32'd15, 32'hFFFF_FFFD};
        run_frame(mk(32'hFFFF_FFFD, 32'd50, 8'd8, 8'd0, 8'd9, 1'b0),
                  mk(32'hFFFF_FFFD, 32'd50, 8'd7, 8'd0, 8'd7, 1'b1));
        drain();

        // All-equal negative frame.
        vq = '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        run_frame(mk(32'hFFFF_FFFB, 32'hFFFF_FFFB, 8'd0, 8'd0, 8'd3, 1'b0),
                  mk(32'hFFFF_FFFB, 32'hFFFF_FFFB, 8'd0, 8'd0, 8'd3, 1'b0));
        drain();

        // Asynchronous reset two beats into a frame.
        send_beat(32'd11, 1'b0);
        send_beat(32'd12, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        vq = '{32'd4};
        run_frame(mk(32'd4, 32'd4, 8'd0, 8'd0, 8'd1, 1'b0),
                  mk(32'd4, 32'd4, 8'd0, 8'd0, 8'd1, 1'b0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
